// File: rtl/sdram_read_master.sv
`default_nettype none
// ============================================================================
// sdram_read_master : credit-limited single-word AXI read issuer with FWFT FIFO
// Rev 1.0
// ============================================================================
module sdram_read_master #(
  parameter int ADDR_WIDTH = 25,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic [ADDR_WIDTH-1:0] s_axi_araddr,
  output logic                  s_axi_arvalid,
  input  logic                  s_axi_arready,
  input  logic [DATA_WIDTH-1:0] s_axi_rdata,
  input  logic                  s_axi_rvalid,
  output logic                  s_axi_rready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int USED_W = CNT_W + 1;
  localparam logic [USED_W-1:0] DEPTH_C = USED_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  out_cnt_q, out_cnt_d;
  logic [CNT_W-1:0]      inflight_q, inflight_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [USED_W-1:0]     used_w;
  logic                  cmd_hs_w;
  logic                  ar_hs_w;
  logic                  r_push_w;
  logic                  out_hs_w;

  // Credits cover both requests in flight and words already buffered, so
  // every returning beat is guaranteed a FIFO slot.
  assign used_w        = {1'b0, inflight_q} + {1'b0, count_q};

  assign cmd_ready     = (state_q == ST_IDLE) && !reset;
  assign s_axi_arvalid = (state_q == ST_RUN) && (rem_q != '0) && (used_w < DEPTH_C);
  assign s_axi_araddr  = addr_q;
  assign s_axi_rready  = !reset;
  assign out_valid     = (count_q != '0);
  assign out_data      = mem_q[rd_ptr_q];
  assign out_last      = out_valid && (out_cnt_q == (len_q - LEN_WIDTH'(1)));
  assign busy          = (state_q != ST_IDLE);

  assign cmd_hs_w      = cmd_valid && cmd_ready;
  assign ar_hs_w       = s_axi_arvalid && s_axi_arready;
  // Beats with nothing outstanding are stray and dropped.
  assign r_push_w      = s_axi_rvalid && s_axi_rready && (inflight_q != '0);
  assign out_hs_w      = out_valid && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      len_q      <= '0;
      out_cnt_q  <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      len_q      <= len_d;
      out_cnt_q  <= out_cnt_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (r_push_w) begin
      mem_q[wr_ptr_q] <= s_axi_rdata;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    len_d      = len_q;
    out_cnt_d  = out_cnt_q;
    inflight_d = inflight_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_hs_w && (cmd_len != '0)) begin
          addr_d    = cmd_addr;
          rem_d     = cmd_len;
          len_d     = cmd_len;
          out_cnt_d = '0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (ar_hs_w && (rem_q == LEN_WIDTH'(1))) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_hs_w && out_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (ar_hs_w) begin
      addr_d = addr_q + ADDR_WIDTH'(1);
      rem_d  = rem_q - LEN_WIDTH'(1);
    end

    case ({ar_hs_w, r_push_w})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase

    case ({r_push_w, out_hs_w})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (r_push_w) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (out_hs_w) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      out_cnt_d = out_cnt_q + LEN_WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sdram_read_master.sv
`default_nettype none
// ============================================================================
// tb_sdram_read_master : directed bench with an in-order single-beat responder
// Rev 1.0
// ============================================================================
module tb_sdram_read_master;

  logic        clk;
  logic        reset;
  logic [24:0] cmd_addr;
  logic [15:0] cmd_len;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [24:0] s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [15:0] s_axi_rdata;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [24:0] arq[$];
  logic [24:0] arlog[$];
  logic [16:0] outlog[$];

  sdram_read_master #(
    .ADDR_WIDTH(25), .DATA_WIDTH(16), .LEN_WIDTH(16), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: log handshakes about to happen, then let the responder
  // present the next outstanding beat (one-cycle minimum latency).
  task automatic cyc();
    logic [24:0] a;
    #1;
    if (s_axi_arvalid && s_axi_arready) begin
      arq.push_back(s_axi_araddr);
      arlog.push_back(s_axi_araddr);
    end
    if (out_valid && out_ready) outlog.push_back({out_last, out_data});
    @(posedge clk);
    @(negedge clk);
    if (!reset && arq.size() > 0) begin
      a            = arq.pop_front();
      s_axi_rvalid = 1'b1;
      s_axi_rdata  = a[15:0] ^ 16'hA5A5;
    end else begin
      s_axi_rvalid = 1'b0;
    end
    #1;
  endtask

  task automatic start_cmd(input logic [24:0] a, input logic [15:0] n);
    arlog.delete();
    outlog.delete();
    cmd_addr  = a;
    cmd_len   = n;
    cmd_valid = 1'b1;
    cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic run_until_idle(input string tag);
    for (int n = 0; n < 200 && busy; n++) cyc();
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; cmd_addr = '0; cmd_len = '0; cmd_valid = 1'b0;
    s_axi_arready = 1'b0; s_axi_rdata = '0; s_axi_rvalid = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("rst_arvalid",   {31'd0, s_axi_arvalid}, 32'd0);
    chk("rst_araddr",    {7'd0, s_axi_araddr}, 32'd0);
    chk("rst_rready",    {31'd0, s_axi_rready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_last",  {31'd0, out_last}, 32'd0);
    chk("rst_busy",      {31'd0, busy}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rel_rready",    {31'd0, s_axi_rready}, 32'd1);

    // Basic three-word read
    s_axi_arready = 1'b1; out_ready = 1'b1;
    start_cmd(25'h10, 16'd3);
    chk("basic_busy", {31'd0, busy}, 32'd1);
    run_until_idle("basic_idle");
    chk("basic_ar_n",  arlog.size(), 32'd3);
    chk("basic_ar0",   {7'd0, arlog[0]}, 32'h10);
    chk("basic_ar1",   {7'd0, arlog[1]}, 32'h11);
    chk("basic_ar2",   {7'd0, arlog[2]}, 32'h12);
    chk("basic_out_n", outlog.size(), 32'd3);
    chk("basic_out0",  {15'd0, outlog[0]}, 32'h0A5B5);
    chk("basic_out1",  {15'd0, outlog[1]}, 32'h0A5B4);
    chk("basic_out2",  {15'd0, outlog[2]}, 32'h1A5B7);
    chk("basic_cmd_ready_after", {31'd0, cmd_ready}, 32'd1);

    // Output stall: credit limit caps issue at the FIFO depth
    out_ready = 1'b0;
    start_cmd(25'h100, 16'd8);
    repeat (20) cyc();
    chk("stall_ar_n",      arlog.size(), 32'd4);
    chk("stall_arvalid",   {31'd0, s_axi_arvalid}, 32'd0);
    chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
    chk("stall_head",      {16'd0, out_data}, 32'h0000A4A5);
    chk("stall_last",      {31'd0, out_last}, 32'd0);
    out_ready = 1'b1;
    run_until_idle("stall_idle");
    chk("stall_ar_total", arlog.size(), 32'd8);
    chk("stall_out_n",    outlog.size(), 32'd8);
    for (int i = 0; i < 8; i++) begin
      logic [24:0] ea;
      logic [15:0] ed;
      ea = 25'h100 + 25'(i);
      ed = ea[15:0] ^ 16'hA5A5;
      chk($sformatf("stall_ar%0d", i), {7'd0, arlog[i]}, {7'd0, ea});
      chk($sformatf("stall_out%0d", i), {15'd0, outlog[i]}, {15'd0, (i == 7), ed});
    end

    // AR backpressure: address held stable while arready is low
    s_axi_arready = 1'b0;
    start_cmd(25'h200, 16'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_arvalid", {31'd0, s_axi_arvalid}, 32'd1);
      chk("bp_araddr",  {7'd0, s_axi_araddr}, 32'h200);
      cyc();
    end
    s_axi_arready = 1'b1;
    run_until_idle("bp_idle");
    chk("bp_ar_n",  arlog.size(), 32'd1);
    chk("bp_out0",  {15'd0, outlog[0]}, 32'h1A7A5);

    // Address wrap at the top of the space
    start_cmd(25'h1FFFFFF, 16'd2);
    run_until_idle("wrap_idle");
    chk("wrap_ar0",  {7'd0, arlog[0]}, 32'h01FFFFFF);
    chk("wrap_ar1",  {7'd0, arlog[1]}, 32'h0);
    chk("wrap_out0", {15'd0, outlog[0]}, 32'h05A5A);
    chk("wrap_out1", {15'd0, outlog[1]}, 32'h1A5A5);

    // Zero-length command is a no-op
    start_cmd(25'h300, 16'd0);
    chk("zero_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("zero_busy",      {31'd0, busy}, 32'd0);
    chk("zero_arvalid",   {31'd0, s_axi_arvalid}, 32'd0);
    repeat (4) cyc();
    chk("zero_ar_n",  arlog.size(), 32'd0);
    chk("zero_out_n", outlog.size(), 32'd0);

    // Reset in the middle of a command
    start_cmd(25'h40, 16'd6);
    for (int n = 0; n < 50 && arlog.size() < 2; n++) cyc();
    chk("mid_ar_n_before", arlog.size(), 32'd2);
    reset = 1'b1;
    s_axi_rvalid = 1'b0;
    arq.delete();
    #1;
    chk("mid_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("mid_arvalid",   {31'd0, s_axi_arvalid}, 32'd0);
    chk("mid_araddr",    {7'd0, s_axi_araddr}, 32'd0);
    chk("mid_rready",    {31'd0, s_axi_rready}, 32'd0);
    chk("mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_out_last",  {31'd0, out_last}, 32'd0);
    chk("mid_busy",      {31'd0, busy}, 32'd0);
    repeat (2) cyc();
    reset = 1'b0;
    repeat (3) cyc();
    chk("mid_ar_n_after", arlog.size(), 32'd2);
    chk("mid_no_out",     outlog.size(), 32'd0);
    start_cmd(25'h20, 16'd2);
    run_until_idle("post_idle");
    chk("post_ar_n",  arlog.size(), 32'd2);
    chk("post_ar0",   {7'd0, arlog[0]}, 32'h20);
    chk("post_out_n", outlog.size(), 32'd2);
    chk("post_out0",  {15'd0, outlog[0]}, 32'h0A585);
    chk("post_out1",  {15'd0, outlog[1]}, 32'h1A584);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
